// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default oversampling ratio
// and frame data width.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int OVERSAMPLE_DEFAULT = 16;
    localparam int UART_DATA_BITS     = 8;

endpackage

// File: rtl/uart_rx_os_if.sv
// Byte-delivery interface of the oversampling receiver: valid/ready holding
// register plus the per-frame status pulses.
interface uart_rx_os_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] dout;
    logic                      dout_valid;
    logic                      dout_ready;
    logic                      frame_err;
    logic                      overrun;

    modport master (
        output dout,
        output dout_valid,
        input  dout_ready,
        output frame_err,
        output overrun
    );

    modport slave (
        input  dout,
        input  dout_valid,
        output dout_ready,
        input  frame_err,
        input  overrun
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: counts 0..baud_div while enabled and pulses
// tick on the terminal count. Held at zero while disabled so every frame
// starts with a fresh phase.
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [DIV_W-1:0] baud_div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_r;

    assign tick = enable && (cnt_r == baud_div);

    // Divider counter: cleared when idle, wraps after the terminal count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {DIV_W{1'b0}};
        end else if (!enable) begin
            cnt_r <= {DIV_W{1'b0}};
        end else if (cnt_r == baud_div) begin
            cnt_r <= {DIV_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver. The line is synchronised, the start bit is
// qualified at mid-bit, data bits are captured LSB-first at bit centres and
// the stop bit decides between delivering the byte, flagging a framing error
// or flagging an overrun when the holding register is still occupied.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter int DIV_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rxd,
    input  logic [DIV_W-1:0] baud_div,
    output logic             busy,
    uart_rx_os_if.master     rx
);

    localparam int SC_W = $clog2(OVERSAMPLE);
    localparam int BI_W = $clog2(UART_DATA_BITS);
    localparam logic [SC_W-1:0] SC_HALF = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
    localparam logic [BI_W-1:0] BI_LAST = BI_W'(UART_DATA_BITS - 1);

    // Input path
    logic sync1_r;
    logic rxs_r;
    logic rxd_q_r;
    logic fall_s;

    // Timing
    logic            enable_s;
    logic            tick_s;
    logic            half_tick_s;
    logic            full_tick_s;
    logic [SC_W-1:0] sc_r;
    logic [BI_W-1:0] bit_idx_r;

    // FSM and controls
    uart_state_e state_r;
    uart_state_e state_next_s;
    logic        shift_en_s;
    logic        stop_tick_s;
    logic        sc_clr_s;
    logic        sc_inc_s;
    logic        bit_clr_s;
    logic        bit_inc_s;

    // Data and holding register
    logic [UART_DATA_BITS-1:0] shift_r;
    logic [UART_DATA_BITS-1:0] dout_r;
    logic                      dout_valid_r;
    logic                      frame_err_r;
    logic                      overrun_r;
    logic                      busy_r;
    logic                      load_s;
    logic                      drop_s;
    logic                      ferr_s;

    // A falling edge is only seen when the previous sample was high, so a
    // line held low (break) never retriggers a frame.
    assign fall_s      = rxd_q_r && !rxs_r;
    assign enable_s    = (state_r != IDLE);
    assign half_tick_s = tick_s && (sc_r == SC_HALF);
    assign full_tick_s = tick_s && (sc_r == SC_LAST);

    uart_baud_tick #(
        .DIV_W (DIV_W)
    ) u_baud_tick (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable_s),
        .baud_div (baud_div),
        .tick     (tick_s)
    );

    // Two-flop synchroniser plus edge-detect register, all idling high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 1'b1;
            rxs_r   <= 1'b1;
            rxd_q_r <= 1'b1;
        end else begin
            sync1_r <= rxd;
            rxs_r   <= sync1_r;
            rxd_q_r <= rxs_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (fall_s) state_next_s = START;
                else        state_next_s = IDLE;
            end
            START: begin
                if (half_tick_s) state_next_s = rxs_r ? IDLE : DATA;
                else             state_next_s = START;
            end
            DATA: begin
                if (full_tick_s && (bit_idx_r == BI_LAST)) state_next_s = STOP;
                else                                       state_next_s = DATA;
            end
            STOP: begin
                if (full_tick_s) state_next_s = IDLE;
                else             state_next_s = STOP;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM output decode: counter controls, shift enable and stop strobe.
    always_comb begin
        shift_en_s  = 1'b0;
        stop_tick_s = 1'b0;
        sc_clr_s    = 1'b0;
        sc_inc_s    = 1'b0;
        bit_clr_s   = 1'b0;
        bit_inc_s   = 1'b0;
        case (state_r)
            IDLE: begin
                sc_clr_s  = 1'b1;
                bit_clr_s = 1'b1;
            end
            START: begin
                bit_clr_s = 1'b1;
                if (half_tick_s) sc_clr_s = 1'b1;
                else             sc_inc_s = tick_s;
            end
            DATA: begin
                if (full_tick_s) begin
                    sc_clr_s   = 1'b1;
                    shift_en_s = 1'b1;
                    bit_inc_s  = 1'b1;
                end else begin
                    sc_inc_s = tick_s;
                end
            end
            STOP: begin
                if (full_tick_s) begin
                    sc_clr_s    = 1'b1;
                    stop_tick_s = 1'b1;
                end else begin
                    sc_inc_s = tick_s;
                end
            end
            default: begin
                sc_clr_s  = 1'b1;
                bit_clr_s = 1'b1;
            end
        endcase
    end

    // Sample counter, bit index and LSB-first shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sc_r      <= {SC_W{1'b0}};
            bit_idx_r <= {BI_W{1'b0}};
            shift_r   <= {UART_DATA_BITS{1'b0}};
        end else begin
            if (sc_clr_s)      sc_r <= {SC_W{1'b0}};
            else if (sc_inc_s) sc_r <= sc_r + SC_W'(1);
            else               sc_r <= sc_r;

            if (bit_clr_s)      bit_idx_r <= {BI_W{1'b0}};
            else if (bit_inc_s) bit_idx_r <= bit_idx_r + BI_W'(1);
            else                bit_idx_r <= bit_idx_r;

            if (shift_en_s) shift_r <= {rxs_r, shift_r[UART_DATA_BITS-1:1]};
            else            shift_r <= shift_r;
        end
    end

    // Stop-bit outcome: deliver, drop as overrun, or flag a framing error.
    always_comb begin
        load_s = 1'b0;
        drop_s = 1'b0;
        ferr_s = 1'b0;
        if (stop_tick_s) begin
            if (!rxs_r)                                  ferr_s = 1'b1;
            else if (!dout_valid_r || rx.dout_ready)     load_s = 1'b1;
            else                                         drop_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
    end

    // Holding register, status pulses and registered busy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_r       <= {UART_DATA_BITS{1'b0}};
            dout_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            frame_err_r <= ferr_s;
            overrun_r   <= drop_s;
            busy_r      <= (state_next_s != IDLE);
            if (load_s) begin
                dout_r       <= shift_r;
                dout_valid_r <= 1'b1;
            end else if (dout_valid_r && rx.dout_ready) begin
                dout_valid_r <= 1'b0;
            end else begin
                dout_valid_r <= dout_valid_r;
            end
        end
    end

    assign rx.dout       = dout_r;
    assign rx.dout_valid = dout_valid_r;
    assign rx.frame_err  = frame_err_r;
    assign rx.overrun    = overrun_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os at baud_div=3 (64 clk per bit). Frames are
// driven bit by bit; each byte expected to be delivered is pushed to a
// scoreboard queue and checked when the consumer accepts it.
module tb_uart_rx_os;

    localparam int BIT_CLK = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        rxd;
    logic [15:0] baud_div;
    logic        busy;

    uart_rx_os_if rx_if ();

    int cmp_cnt = 0;
    int err_cnt = 0;
    int fe_cnt  = 0;
    int ov_cnt  = 0;
    int acc_cnt = 0;
    logic [7:0] sb_q[$];

    uart_rx_os #(
        .OVERSAMPLE (16),
        .DIV_W      (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .baud_div (baud_div),
        .busy     (busy),
        .rx       (rx_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic idle_level);
        rxd = 1'b0;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            rxd = data[i];
            wait_clk(BIT_CLK);
        end
        rxd = stop_bit;
        wait_clk(BIT_CLK);
        rxd = idle_level;
    endtask

    // Monitor: count status pulses and check accepted bytes against the scoreboard.
    always @(negedge clk) begin
        if (rx_if.frame_err === 1'b1) fe_cnt++;
        if (rx_if.overrun === 1'b1) ov_cnt++;
        if (rx_if.dout_valid === 1'b1 && rx_if.dout_ready === 1'b1) begin
            acc_cnt++;
            check("sb_nonempty", {31'd0, (sb_q.size() != 0)}, 32'd1);
            if (sb_q.size() != 0) begin
                logic [7:0] exp_b;
                exp_b = sb_q.pop_front();
                check("sb_dout", {24'd0, rx_if.dout}, {24'd0, exp_b});
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc_base;
        rst              = 1'b0;
        rxd              = 1'b1;
        baud_div         = 16'd3;
        rx_if.dout_ready = 1'b0;

        // Reset state
        wait_clk(5);
        check("rst_dout",  {24'd0, rx_if.dout},       32'h00);
        check("rst_valid", {31'd0, rx_if.dout_valid}, 32'd0);
        check("rst_ferr",  {31'd0, rx_if.frame_err},  32'd0);
        check("rst_ovr",   {31'd0, rx_if.overrun},    32'd0);
        check("rst_busy",  {31'd0, busy},             32'd0);
        rst = 1'b1;
        wait_clk(10);

        // Good frame 0x33, held until accepted
        sb_q.push_back(8'h33);
        send_frame(8'h33, 1'b1, 1'b1);
        check("b33_valid", {31'd0, rx_if.dout_valid}, 32'd1);
        check("b33_dout",  {24'd0, rx_if.dout},       32'h33);
        check("b33_ferr",  32'(fe_cnt),               32'd0);
        wait_clk(20);
        check("b33_hold",  {31'd0, rx_if.dout_valid}, 32'd1);
        rx_if.dout_ready = 1'b1;
        wait_clk(1);
        rx_if.dout_ready = 1'b0;
        check("b33_clear", {31'd0, rx_if.dout_valid}, 32'd0);
        check("b33_acc",   32'(acc_cnt),              32'd1);

        // Start glitch: low for two ticks only
        rxd = 1'b0;
        wait_clk(8);
        check("glitch_busy", {31'd0, busy}, 32'd1);
        rxd = 1'b1;
        wait_clk(100);
        check("glitch_idle",  {31'd0, busy},             32'd0);
        check("glitch_valid", {31'd0, rx_if.dout_valid}, 32'd0);
        check("glitch_ferr",  32'(fe_cnt),               32'd0);

        // Framing error on 0xA5, then line held low (break)
        send_frame(8'hA5, 1'b0, 1'b0);
        check("fe_cnt",   32'(fe_cnt),               32'd1);
        check("fe_valid", {31'd0, rx_if.dout_valid}, 32'd0);
        wait_clk(300);
        check("brk_busy", {31'd0, busy},             32'd0);
        check("brk_fe",   32'(fe_cnt),               32'd1);
        check("brk_valid",{31'd0, rx_if.dout_valid}, 32'd0);
        rxd = 1'b1;
        wait_clk(40);

        // Overrun: 0x11 held, 0x22 dropped
        sb_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b1);
        wait_clk(10);
        check("ovr_cnt",   32'(ov_cnt),               32'd1);
        check("ovr_dout",  {24'd0, rx_if.dout},       32'h11);
        check("ovr_valid", {31'd0, rx_if.dout_valid}, 32'd1);
        rx_if.dout_ready = 1'b1;
        wait_clk(1);
        check("ovr_clear", {31'd0, rx_if.dout_valid}, 32'd0);

        // Back-to-back frames with one-bit gaps, ready held high
        acc_base = acc_cnt;
        sb_q.push_back(8'h00);
        sb_q.push_back(8'hFF);
        sb_q.push_back(8'h55);
        send_frame(8'h00, 1'b1, 1'b1);
        wait_clk(BIT_CLK);
        send_frame(8'hFF, 1'b1, 1'b1);
        wait_clk(BIT_CLK);
        send_frame(8'h55, 1'b1, 1'b1);
        wait_clk(20);
        check("b2b_acc",   32'(acc_cnt - acc_base), 32'd3);
        check("b2b_ovr",   32'(ov_cnt),             32'd1);
        check("b2b_empty", 32'(sb_q.size()),        32'd0);

        // Reset during bit 4 of 0xC3, released while the line is high (bit 6)
        acc_base = acc_cnt;
        rxd = 1'b0;
        wait_clk(BIT_CLK);
        for (int i = 0; i < 4; i++) begin
            rxd = (i < 2) ? 1'b1 : 1'b0;
            wait_clk(BIT_CLK);
        end
        rxd = 1'b0;
        wait_clk(30);
        rst = 1'b0;
        wait_clk(4);
        check("mrst_dout",  {24'd0, rx_if.dout},       32'h00);
        check("mrst_valid", {31'd0, rx_if.dout_valid}, 32'd0);
        check("mrst_ferr",  {31'd0, rx_if.frame_err},  32'd0);
        check("mrst_ovr",   {31'd0, rx_if.overrun},    32'd0);
        check("mrst_busy",  {31'd0, busy},             32'd0);
        wait_clk(BIT_CLK - 34);
        wait_clk(BIT_CLK);
        rxd = 1'b1;
        wait_clk(30);
        rst = 1'b1;
        wait_clk(BIT_CLK - 30);
        wait_clk(3 * BIT_CLK);
        check("mrst_idle", {31'd0, busy},    32'd0);
        check("mrst_none", 32'(acc_cnt - acc_base), 32'd0);

        sb_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b1);
        wait_clk(20);
        check("post_acc",   32'(acc_cnt - acc_base), 32'd1);
        check("post_empty", 32'(sb_q.size()),        32'd0);
        check("post_fe",    32'(fe_cnt),             32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Oversampling UART receiver: the receive end of the team's 8N1 UART link, recovering bytes sent by the transmitter at the far end. It samples the line at 16x the baud rate, qualifies the start bit at mid-bit, captures 8 data bits LSB-first at bit centres and checks the stop bit. It presents each byte through a valid/ready holding register and flags framing errors and overruns. It replaces the single-sample receiver in the top-level UART path.

## Interface
- OVERSAMPLE, 16: ticks per bit; power of two, ≥ 8.
- DIV_W, 16: width of the baud divisor.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- rxd  in  1  serial line, asynchronous to clk, idle high.
- baud_div  in  DIV_W  clk cycles per oversample tick minus 1; quasi-static, changes only while busy=0.
- dout  out  8  received byte; stable while dout_valid=1.
- dout_valid  out  1  byte available in the holding register.
- dout_ready  in  1  consumer accepts dout when dout_valid=1.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- overrun  out  1  one-cycle pulse: good byte arrived while holding register full; the byte is dropped.
- busy  out  1  FSM not in IDLE.

## Operation
- Input path: 2-flop synchronizer on rxd, both flops reset to 1; one more register (rxd_q) for edge detect. All FSM decisions use the synchronized value rxs.
- Tick generator: counter 0..baud_div, held at 0 in IDLE; tick=1 for one clk when counter==baud_div, then wraps to 0. With baud_div=0 a tick fires every cycle.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: on falling edge (rxd_q=1, rxs=0) → START; tick counter and sample counter cleared. A line held low (break) causes no retrigger.
  - START: on tick OVERSAMPLE/2: rxs=0 → DATA with sample counter and bit index cleared; rxs=1 → IDLE (glitch, no outputs).
  - DATA: on every OVERSAMPLE-th tick shift rxs into shift[7] (right shift, LSB first); after bit 7 → STOP.
  - STOP: on OVERSAMPLE-th tick sample rxs, → IDLE in the same cycle (mid-stop-bit).
- Stop result, registered one cycle after the stop-sample tick:
  - rxs=0: frame_err pulse; holding register untouched.
  - rxs=1, dout_valid=0 or (dout_valid=1 and dout_ready=1): dout←shift, dout_valid=1.
  - rxs=1, dout_valid=1 and dout_ready=0: overrun pulse, byte dropped, dout unchanged.
- Handshake: dout_valid clears the cycle after dout_valid&&dout_ready unless a new byte loads in that same cycle, in which case it stays 1 with the new dout.
- Reset values: dout=8'h00, dout_valid=0, frame_err=0, overrun=0, busy=0, FSM=IDLE, synchronizer flops=1.
- Reset asserted mid-frame: all state cleared immediately; after release the receiver waits for a fresh falling edge, so partial frames are never delivered.

## Timing
- rxd pin to falling-edge detect: 2 clk (synchronizer).
- Let T = (baud_div+1) clk per tick, B = OVERSAMPLE·T per bit.
- Start sample at edge detect + (OVERSAMPLE/2)·T; data bit n sampled at start sample + (n+1)·B; stop sampled at start sample + 9·B.
- dout_valid / frame_err / overrun assert 1 clk after the stop-sample tick.
- Tolerates ±3% baud mismatch at OVERSAMPLE=16.
- Back-to-back frames: a next start edge half a bit after the stop sample is accepted.

## Structure
- Shared package uart_pkg: FSM state enum (IDLE/START/DATA/STOP), OVERSAMPLE default, UART_DATA_BITS=8.
- Sub-module uart_baud_tick (enable, baud_div → tick). The transmitter reuses it with enable tied high.
- Synchronizer, FSM and holding register stay in uart_rx_os.

## Test plan
- baud_div=3 (64 clk/bit), send 0x33 with good stop → dout=8'h33, dout_valid=1 until dout_ready; frame_err=0.
- rxd low for 2 ticks then high → START aborts to IDLE; no dout_valid, no frame_err; busy returns to 0.
- Send 0xA5 with stop bit 0 → frame_err pulses 1 clk, dout_valid stays 0; line held low afterwards causes no new frame.
- Send 0x11 then 0x22 with dout_ready=0 → dout=8'h11 retained, overrun pulses once at the second stop; then dout_ready=1 → dout_valid clears.
- dout_ready tied 1, back-to-back 0x00, 0xFF, 0x55 with 1-bit gaps → three valid pulses with matching dout, no overrun.
- Assert rst (low) during bit 4 of 0xC3, release, send 0x3C → only 0x3C delivered; all outputs at reset values while rst=0.
